// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Receives a byte-serial load image and turns it into 32-bit instruction
// memory writes. The image is:
//   bank byte   : bit 0 selects the ROM bank (0 = upper, 1 = lower)
//   count hi/lo : big-endian word count, low 10 bits used, valid range 1..512
//   data        : count * 4 bytes, each word big-endian
//   checksum    : one byte, XOR of all data bytes (only with LOADER_CHECKSUM_EN)
//
// Configuration macro: LOADER_CHECKSUM_EN
//   defined   -> running XOR over data bytes, checksum byte checked in CHK
//   undefined -> no CHK state, DATA goes straight to DONE
//
// Ports
//   clk            in   single clock, rising edge
//   rst_n          in   synchronous active-low reset
//   start          in   pulse, begins a load session (ignored while busy)
//   byte_in[7:0]   in   stream byte
//   byte_valid     in   byte_in valid
//   byte_ready     out  loader accepts a byte this cycle
//   wr_en          out  one-cycle write strobe
//   wr_bank        out  bank select for the write
//   wr_addr[8:0]   out  word address of the write
//   wr_data[31:0]  out  instruction word
//   busy           out  session in progress
//   done           out  sticky, last session completed cleanly
//   error          out  sticky, last session aborted
//   words_written[9:0] out  words written in the current or last session
// -----------------------------------------------------------------------------
module instr_mem_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic        wr_bank,
    output logic [8:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [9:0]  words_written
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_BANK,
        HDR_CNT_HI,
        HDR_CNT_LO,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  cnt_hi;        // only the low 2 bits of the high count byte matter
    logic [9:0]  word_count;
    logic [9:0]  words_rcvd;    // words whose 4th byte has been accepted
    logic [1:0]  byte_idx;      // position of the next data byte within its word
    logic [23:0] shift;         // first three bytes of the word being assembled
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_acc;
`endif

    logic        xfer;
    logic [9:0]  cnt_full;
    logic        all_rcvd;
    logic        last_strobe;

    assign xfer        = byte_valid && byte_ready;
    assign cnt_full    = {cnt_hi, byte_in};
    assign all_rcvd    = (words_rcvd == word_count);
    // words_written is bumped on the same edge that raises wr_en, so during
    // the final strobe it already equals the session's word count.
    assign last_strobe = wr_en && (words_written == word_count);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = HDR_BANK;
            end
            HDR_BANK: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) state_next = HDR_CNT_HI;
            end
            HDR_CNT_HI: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) state_next = HDR_CNT_LO;
            end
            HDR_CNT_LO: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (cnt_full == 10'd0 || cnt_full > 10'd512) state_next = ERR;
                    else                                         state_next = DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                // Stop taking bytes once the last word is assembled; the
                // following byte (checksum or next image) must wait until
                // the final strobe has gone out and DATA has been left.
                byte_ready = !all_rcvd;
                if (last_strobe) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (byte_in == xor_acc) state_next = DONE;
                    else                    state_next = ERR;
                end
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_next = HDR_BANK;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_next = HDR_BANK;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: header capture, word assembly, write strobe and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: working registers are reset too, so an aborted session
            // leaves nothing half-assembled that could leak into the next.
            wr_en         <= 1'b0;
            wr_bank       <= 1'b0;
            wr_addr       <= 9'd0;
            wr_data       <= 32'd0;
            words_written <= 10'd0;
            cnt_hi        <= 2'd0;
            word_count    <= 10'd0;
            words_rcvd    <= 10'd0;
            byte_idx      <= 2'd0;
            shift         <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc       <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge values of the others.
            wr_en <= 1'b0;

            // Address advances after each strobe; it is left on the last
            // word's address at the end of a session rather than stepping past it.
            if (wr_en && !last_strobe) wr_addr <= wr_addr + 9'd1;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        wr_addr       <= 9'd0;
                        words_written <= 10'd0;
                        words_rcvd    <= 10'd0;
                        byte_idx      <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        xor_acc       <= 8'd0;
`endif
                    end
                end
                HDR_BANK: begin
                    if (xfer) wr_bank <= byte_in[0];
                end
                HDR_CNT_HI: begin
                    if (xfer) cnt_hi <= byte_in[1:0];
                end
                HDR_CNT_LO: begin
                    if (xfer) word_count <= cnt_full;
                end
                DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        xor_acc  <= xor_acc ^ byte_in;
`endif
                        if (byte_idx == 2'd3) begin
                            wr_data       <= {shift, byte_in};
                            wr_en         <= 1'b1;
                            words_written <= words_written + 10'd1;
                            words_rcvd    <= words_rcvd + 10'd1;
                        end else begin
                            shift <= {shift[15:0], byte_in};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Self-checking bench for instr_mem_loader. Each session's expected writes
// and final status are computed directly from the byte image handed to the
// DUT; observed writes are collected by a monitor on the falling edge.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic        wr_bank;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  words_written;

    instr_mem_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .wr_en         (wr_en),
        .wr_bank       (wr_bank),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [41:0] got_q[$];     // {bank, addr, data} of each observed write
    logic [7:0]  dq[$];        // data bytes of the next session
    int          dbl = 0;      // wr_en seen high on two consecutive cycles
    logic        prev_wr_en = 1'b0;

    always @(negedge clk) begin
        if (wr_en) got_q.push_back({wr_bank, wr_addr, wr_data});
        if (wr_en && prev_wr_en) dbl++;
        prev_wr_en = wr_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte (after optional random idle cycles) and hold it until
    // the loader takes it. Returns the number of cycles it was refused.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, output int stalls);
        stalls = 0;
        while ($urandom_range(99, 0) < gap_pct) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        #1;
        while (!byte_ready && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!byte_ready) check("ready_timeout", 0, 1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_not_busy();
        for (int t = 0; t < 100 && busy; t++) @(negedge clk);
    endtask

    // One complete session built from the header bytes and dq[].
    task automatic run_session(input string tag, input logic [7:0] bank_b,
                               input logic [7:0] hi, input logic [7:0] lo,
                               input bit bad_chk, input int gap_pct,
                               input int mid_start_at, input bit full_rate);
        int          n;
        bit          bad;
        bit          exp_err;
        logic [7:0]  x;
        logic [7:0]  chk_byte;
        int          stalls;
        int          tot;
        logic [41:0] exp_q[$];

        // Reference model straight from the image format.
        n   = (int'(hi) * 256 + int'(lo)) % 1024;
        bad = (n == 0) || (n > 512);
        x   = 8'h00;
        foreach (dq[i]) x ^= dq[i];
        chk_byte = bad_chk ? (x ^ 8'h01) : x;
        exp_err  = bad || (CHK_EN && bad_chk);
        exp_q.delete();
        if (!bad)
            for (int w = 0; w < n; w++)
                exp_q.push_back({bank_b[0], 9'(w), dq[4*w], dq[4*w+1], dq[4*w+2], dq[4*w+3]});

        pulse_start();
        got_q.delete();
        dbl = 0;

        send_byte(bank_b, gap_pct, stalls);
        check({tag, "/busy_mid"}, 64'(busy), 1);
        send_byte(hi, gap_pct, stalls);
        send_byte(lo, gap_pct, stalls);
        if (!bad) begin
            tot = 0;
            for (int i = 0; i < 4 * n; i++) begin
                if (i == mid_start_at) pulse_start();
                send_byte(dq[i], gap_pct, stalls);
                tot += stalls;
            end
            if (full_rate) check({tag, "/data_stalls"}, 64'(tot), 0);
`ifdef LOADER_CHECKSUM_EN
            send_byte(chk_byte, gap_pct, stalls);
`endif
        end
        wait_not_busy();

        check({tag, "/busy_end"}, 64'(busy), 0);
        check({tag, "/error"}, 64'(error), 64'(exp_err));
        check({tag, "/done"}, 64'(done), 64'(!exp_err));
        check({tag, "/words_written"}, 64'(words_written), bad ? 64'd0 : 64'(n));
        check({tag, "/n_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s/write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, "/double_strobe"}, 64'(dbl), 0);
    endtask

    task automatic load_dq(input logic [31:0] w0, input logic [31:0] w1, input int nw);
        dq.delete();
        if (nw > 0) begin dq.push_back(w0[31:24]); dq.push_back(w0[23:16]); dq.push_back(w0[15:8]); dq.push_back(w0[7:0]); end
        if (nw > 1) begin dq.push_back(w1[31:24]); dq.push_back(w1[23:16]); dq.push_back(w1[15:8]); dq.push_back(w1[7:0]); end
    endtask

    task automatic rand_dq(input int nw);
        dq.delete();
        for (int i = 0; i < 4 * nw; i++) dq.push_back(8'($urandom_range(255, 0)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          stalls;
        int          nw;
        logic [59:0] all_outs;

        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        all_outs = {byte_ready, wr_en, wr_bank, busy, done, error, wr_addr, wr_data, words_written};
        check("reset/outputs", 64'(all_outs), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle/byte_ready", 64'(byte_ready), 0);

        // Two words, bank 0
        load_dq(32'hDEADBEEF, 32'h0000000C, 2);
        run_session("two_words", 8'h00, 8'h00, 8'h02, 1'b0, 0, -1, 1'b1);

        // One word, bank 1, correct checksum
        load_dq(32'h12345678, 32'h0, 1);
        run_session("bank1", 8'h01, 8'h00, 8'h01, 1'b0, 0, -1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        // Same image with checksum 09
        run_session("bad_chk", 8'h01, 8'h00, 8'h01, 1'b1, 0, -1, 1'b1);
`endif

        // Count boundaries
        dq.delete();
        run_session("count0", 8'h00, 8'h00, 8'h00, 1'b0, 0, -1, 1'b0);
        run_session("count513", 8'h00, 8'h02, 8'h01, 1'b0, 0, -1, 1'b0);

        // Only low 10 bits of the count count; bank byte upper bits ignored
        rand_dq(1);
        run_session("cnt_hi_bits", 8'hFE, 8'hFC, 8'h01, 1'b0, 20, -1, 1'b0);

        // Full 512-word image with random valid gaps
        rand_dq(512);
        run_session("count512", 8'h01, 8'h02, 8'h00, 1'b0, 25, -1, 1'b0);

        // Start pulsed mid-session is ignored
        rand_dq(3);
        run_session("mid_start", 8'h00, 8'h00, 8'h03, 1'b0, 10, 5, 1'b0);

        // Reset after two of three words
        rand_dq(3);
        pulse_start();
        got_q.delete();
        dbl = 0;
        send_byte(8'h00, 0, stalls);
        send_byte(8'h00, 0, stalls);
        send_byte(8'h03, 0, stalls);
        for (int i = 0; i < 8; i++) send_byte(dq[i], 0, stalls);
        @(negedge clk);
        send_byte(dq[8], 0, stalls);
        send_byte(dq[9], 0, stalls);
        rst_n = 1'b0;
        @(negedge clk);
        all_outs = {byte_ready, wr_en, wr_bank, busy, done, error, wr_addr, wr_data, words_written};
        check("mid_reset/outputs", 64'(all_outs), 0);
        rst_n = 1'b1;
        byte_in    = dq[10];
        byte_valid = 1'b1;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_reset/n_writes", 64'(got_q.size()), 2);
        if (got_q.size() >= 2) begin
            check("mid_reset/write0", 64'(got_q[0]), 64'({1'b0, 9'd0, dq[0], dq[1], dq[2], dq[3]}));
            check("mid_reset/write1", 64'(got_q[1]), 64'({1'b0, 9'd1, dq[4], dq[5], dq[6], dq[7]}));
        end
        check("mid_reset/idle_busy", 64'(busy), 0);

        // Normal session after the aborted one
        load_dq(32'hCAFEF00D, 32'h01020304, 2);
        run_session("after_reset", 8'h01, 8'h00, 8'h02, 1'b0, 0, -1, 1'b1);

        // A few random small images
        for (int s = 0; s < 4; s++) begin
            nw = $urandom_range(6, 1);
            rand_dq(nw);
            run_session($sformatf("rand%0d", s), 8'($urandom_range(255, 0)), 8'h00, 8'(nw),
                        1'b0, 30, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
